// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider, result = a / b.
// Restoring mantissa division at one quotient bit per clock, truncation rounding.
module fp_div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2
    } state_t;

    localparam logic [4:0] LAST_ITER = 5'd24;

    state_t state, state_nx;

    // operand latch
    logic               sign_r;
    logic signed [9:0]  exp_r;
    logic [23:0]        mant_b_r;
    logic [24:0]        r_r;
    logic [24:0]        q_r;
    logic [4:0]         cnt;
    logic               spec_r;
    logic               dz_r;

    // decode of incoming operands
    logic [7:0]         a_exp, b_exp;
    logic               a_zero, b_zero;
    logic signed [9:0]  exp_in;

    // control strobes
    logic               accept;
    logic               iterate;
    logic               finish;

    // datapath
    logic               ge;
    logic [24:0]        r_sub;
    logic [24:0]        r_nx;
    logic signed [9:0]  e_norm;
    logic [22:0]        frac;
    logic [31:0]        res_nx;

    always_comb begin
        a_exp  = a[30:23];
        b_exp  = b[30:23];
        a_zero = (a_exp == 8'd0);
        b_zero = (b_exp == 8'd0);
        exp_in = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 10'sd127;
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) state_nx = (a_zero || b_zero) ? NORM : DIVIDE;
            end
            DIVIDE: begin
                if (cnt == LAST_ITER) state_nx = NORM;
            end
            NORM:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // output / strobe logic
    always_comb begin
        accept  = 1'b0;
        iterate = 1'b0;
        finish  = 1'b0;
        busy    = 1'b0;
        case (state)
            IDLE:   accept = start;
            DIVIDE: begin
                iterate = 1'b1;
                busy    = 1'b1;
            end
            NORM: begin
                finish = 1'b1;
                busy   = 1'b1;
            end
            default: ;
        endcase
    end

    // one restoring step: subtract if it fits, record the bit, shift
    always_comb begin
        ge    = (r_r >= {1'b0, mant_b_r});
        r_sub = ge ? (r_r - {1'b0, mant_b_r}) : r_r;
        r_nx  = {r_sub[23:0], 1'b0};
    end

    // q lands in [2^23, 2^25), so one of the top two bits is always set
    always_comb begin
        if (q_r[24]) begin
            e_norm = exp_r;
            frac   = q_r[23:1];
        end else begin
            e_norm = exp_r - 10'sd1;
            frac   = q_r[22:0];
        end

        if (spec_r) begin
            res_nx = dz_r ? {sign_r, 8'hFF, 23'h0} : {sign_r, 31'h0};
        end else if (e_norm >= 10'sd255) begin
            res_nx = {sign_r, 8'hFF, 23'h0};
        end else if (e_norm <= 10'sd0) begin
            res_nx = {sign_r, 31'h0};
        end else begin
            res_nx = {sign_r, e_norm[7:0], frac};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sign_r      <= 1'b0;
            exp_r       <= 10'sd0;
            mant_b_r    <= 24'h0;
            r_r         <= 25'h0;
            q_r         <= 25'h0;
            cnt         <= 5'd0;
            spec_r      <= 1'b0;
            dz_r        <= 1'b0;
            done        <= 1'b0;
            result      <= 32'h0;
            div_by_zero <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                sign_r   <= a[31] ^ b[31];
                exp_r    <= exp_in;
                mant_b_r <= {1'b1, b[22:0]};
                r_r      <= {2'b01, a[22:0]};
                q_r      <= 25'h0;
                cnt      <= 5'd0;
                spec_r   <= a_zero | b_zero;
                dz_r     <= b_zero;
            end
            if (iterate) begin
                q_r <= {q_r[23:0], ge};
                r_r <= r_nx;
                cnt <= cnt + 5'd1;
            end
            if (finish) begin
                result      <= res_nx;
                div_by_zero <= spec_r & dz_r;
            end
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed-vector bench for fp_div_seq: hand-computed quotients, latency,
// handshake and reset-abort behaviour.
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a, b;
    logic        busy, done, div_by_zero;
    logic [31:0] result;

    int vecs = 0;
    int miss = 0;

    fp_div_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Steps negedge by negedge until done, counting cycles and busy cycles.
    task automatic wait_done(output int n, output int bc);
        n  = 0;
        bc = 0;
        do begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (busy) bc++;
        end while (!done && n < 80);
    endtask

    task automatic run(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                       input logic [31:0] exp_res, input logic exp_dz, input int exp_lat);
        int n, bc;
        @(negedge clk);
        a = xa; b = xb; start = 1'b1;
        wait_done(n, bc);
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_dz"},  32'(div_by_zero), 32'(exp_dz));
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_busy"}, 32'(bc), 32'(exp_lat - 1));
    endtask

    initial begin
        int n, bc;
        int seen;
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_res",  result, 32'h0);
        chk("rst_dz",   32'(div_by_zero), 32'd0);

        run("six_two",   32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 27);
        @(negedge clk);
        chk("done_1cyc", 32'(done), 32'd0);
        chk("res_hold",  result, 32'h40400000);

        run("one_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 27);
        run("neg_div",   32'hC0F00000, 32'h40200000, 32'hC0400000, 1'b0, 27);
        run("div_zero",  32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 2);
        run("zero_a",    32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 2);
        run("zero_zero", 32'h00000000, 32'h80000000, 32'hFF800000, 1'b1, 2);
        run("ovf",       32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b0, 27);
        run("unf",       32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 27);

        // start pulsed while busy must be ignored
        @(negedge clk);
        a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, bc);
        chk("ign_lat", 32'(n), 32'd21);
        chk("ign_res", result, 32'h40400000);
        @(negedge clk);
        chk("ign_idle", 32'(busy), 32'd0);

        // start in the done cycle is accepted immediately
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
        wait_done(n, bc);
        a = 32'hC0F00000; b = 32'h40200000; start = 1'b1;
        wait_done(n, bc);
        chk("b2b_lat", 32'(n), 32'd27);
        chk("b2b_res", result, 32'hC0400000);

        // reset sampled at edge 10 of a divide aborts it
        @(negedge clk);
        a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_res",  result, 32'h0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_nodone", 32'(seen), 32'd0);
        run("post_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 27);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
